sram_ctrl: RTL and testbench

Clocked controller that turns single-cycle read/write requests, with optional incrementing bursts, into correctly sequenced cycles on an asynchronous SRAM (active-low chip select, output enable and write enable; bidirectional data bus). It sits between the CPU/bus side and an `sram` instance. It supersedes direct strobe driving from testbenches and logic. Data width, address width, burst length and read/write wait states are parameters.

---
 rtl/sram_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_sram_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// Sequencer for an asynchronous SRAM: turns single-cycle read/write requests
// (optionally incrementing bursts) into registered CS/OE/WE strobes and bus drive.
module sram_ctrl #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned BURST_WIDTH = 4,
    parameter int unsigned RD_WAIT     = 2,
    parameter int unsigned WR_WAIT     = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req,
    input  logic                   we,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [BURST_WIDTH-1:0] burst_len,
    input  logic [DATA_WIDTH-1:0]  wdata,
    output logic                   wdata_ack,
    output logic [DATA_WIDTH-1:0]  rdata,
    output logic                   rdata_valid,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    inout  wire  [DATA_WIDTH-1:0]  sram_data,
    output logic                   sram_notCS,
    output logic                   sram_notOE,
    output logic                   sram_notWE
);

    localparam int unsigned WAIT_MAX = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int unsigned WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    localparam logic [WAIT_W-1:0]      RD_LAST   = WAIT_W'(RD_WAIT - 1);
    localparam logic [WAIT_W-1:0]      WR_LAST   = WAIT_W'(WR_WAIT - 1);
    localparam logic [WAIT_W-1:0]      WAIT_ZERO = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0]      WAIT_ONE  = WAIT_W'(1);
    localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [BURST_WIDTH-1:0] BEAT_ZERO = {BURST_WIDTH{1'b0}};
    localparam logic [BURST_WIDTH-1:0] BEAT_ONE  = BURST_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_BEAT  = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4
    } state_t;

    state_t                 state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [ADDR_WIDTH-1:0]  addr_d;
    logic [BURST_WIDTH-1:0] beats_q;
    logic [BURST_WIDTH-1:0] beats_d;
    logic [WAIT_W-1:0]      wait_q;
    logic [WAIT_W-1:0]      wait_d;
    logic [DATA_WIDTH-1:0]  wr_data_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   drive_q;
    logic                   cs_n_q;
    logic                   oe_n_q;
    logic                   we_n_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   rdata_valid_q;
    logic                   wdata_ack_q;

    // Next-beat address (wraps modulo 2^ADDR_WIDTH), remaining beats and wait countdown.
    always_comb begin
        addr_d  = addr_q + ADDR_ONE;
        beats_d = beats_q - BEAT_ONE;
        wait_d  = wait_q - WAIT_ONE;
    end

    // Controller FSM; every SRAM-facing output is a register updated with the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= {ADDR_WIDTH{1'b0}};
            beats_q       <= BEAT_ZERO;
            wait_q        <= WAIT_ZERO;
            wr_data_q     <= {DATA_WIDTH{1'b0}};
            rdata_q       <= {DATA_WIDTH{1'b0}};
            drive_q       <= 1'b0;
            cs_n_q        <= 1'b1;
            oe_n_q        <= 1'b1;
            we_n_q        <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rdata_valid_q <= 1'b0;
            wdata_ack_q   <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            rdata_valid_q <= 1'b0;
            wdata_ack_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q  <= addr;
                        beats_q <= burst_len;
                        busy_q  <= 1'b1;
                        cs_n_q  <= 1'b0;
                        if (we) begin
                            state_q     <= WR_SETUP;
                            wr_data_q   <= wdata;
                            drive_q     <= 1'b1;
                            wdata_ack_q <= 1'b1;
                        end else begin
                            state_q <= RD_BEAT;
                            oe_n_q  <= 1'b0;
                            wait_q  <= RD_LAST;
                        end
                    end
                end
                RD_BEAT: begin
                    if (wait_q == WAIT_ZERO) begin
                        rdata_q       <= sram_data;
                        rdata_valid_q <= 1'b1;
                        if (beats_q == BEAT_ZERO) begin
                            state_q <= IDLE;
                            cs_n_q  <= 1'b1;
                            oe_n_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q  <= addr_d;
                            beats_q <= beats_d;
                            wait_q  <= RD_LAST;
                        end
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                WR_SETUP: begin
                    state_q <= WR_PULSE;
                    we_n_q  <= 1'b0;
                    wait_q  <= WR_LAST;
                end
                WR_PULSE: begin
                    if (wait_q == WAIT_ZERO) begin
                        state_q <= WR_HOLD;
                        we_n_q  <= 1'b1;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                WR_HOLD: begin
                    if (beats_q == BEAT_ZERO) begin
                        state_q <= IDLE;
                        drive_q <= 1'b0;
                        cs_n_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        // Next beat's data is taken here so it is on the bus throughout WR_SETUP.
                        state_q     <= WR_SETUP;
                        addr_q      <= addr_d;
                        beats_q     <= beats_d;
                        wr_data_q   <= wdata;
                        wdata_ack_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    drive_q <= 1'b0;
                    cs_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    we_n_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sram_data   = drive_q ? wr_data_q : {DATA_WIDTH{1'bz}};
    assign sram_addr   = addr_q;
    assign sram_notCS  = cs_n_q;
    assign sram_notOE  = oe_n_q;
    assign sram_notWE  = we_n_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign wdata_ack   = wdata_ack_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: behavioural SRAM, command table, read-data scoreboard
// and hand-written abort and back-to-back sequences.
module tb_sram_ctrl;

    localparam int DW = 4;
    localparam int AW = 4;
    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [3:0]    burst_len;
    logic [DW-1:0] wdata;
    logic          wdata_ack;
    logic [DW-1:0] rdata;
    logic          rdata_valid;
    logic          busy;
    logic          done;
    logic [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_data;
    logic          sram_notCS;
    logic          sram_notOE;
    logic          sram_notWE;

    sram_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WIDTH(4),
        .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr),
        .burst_len(burst_len), .wdata(wdata), .wdata_ack(wdata_ack),
        .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .done(done),
        .sram_addr(sram_addr), .sram_data(sram_data), .sram_notCS(sram_notCS),
        .sram_notOE(sram_notOE), .sram_notWE(sram_notWE)
    );

    always #5 clock = ~clock;

    // Behavioural asynchronous SRAM
    logic [DW-1:0] mem [16];
    logic          init_en;
    assign sram_data = (!sram_notCS && !sram_notOE && sram_notWE) ? mem[sram_addr] : 4'bz;

    always @(posedge clock) begin
        if (init_en) begin
            for (int i = 0; i < 16; i++) mem[i] <= 4'(i) ^ 4'h9;
        end else if (!sram_notCS && !sram_notWE) begin
            mem[sram_addr] <= sram_data;
        end
    end

    int n_chk = 0;
    int n_err = 0;
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] sb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Read-data scoreboard and strobe exclusivity monitor
    always @(negedge clock) begin
        if (!init_en && rdata_valid) begin
            if (sb_q.size() == 0) chk("sb_extra_rdata", 32'd1, 32'd0);
            else chk("rdata", rdata, sb_q.pop_front());
        end
        if (!init_en && !sram_notOE) chk("oe_we_excl", sram_notWE, 1'b1);
    end

    task automatic drive_req(input bit w, input logic [3:0] a, input logic [3:0] bl, input logic [3:0] db);
        logic [3:0] ad;
        req = 1'b1; we = w; addr = a; burst_len = bl; wdata = db;
        for (int i = 0; i <= int'(bl); i++) begin
            ad = a + 4'(i);
            if (w) ref_mem[ad] = db + 4'(i);
            else sb_q.push_back(ref_mem[ad]);
        end
    endtask

    task automatic wait_cmd(input bit w, input logic [3:0] bl, input logic [3:0] db,
                            input int glitch, input int exp_done, input bit chain);
        int cyc = 0, acks = 0, nwe = 0, noe = 0, nrv = 0;
        bit got = 1'b0;
        int n = int'(bl) + 1;
        while (!got && cyc < 400) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) chk("busy_rise", busy, 1'b1);
            if (wdata_ack) begin
                chk("ack_cycle", cyc, 1 + acks * (WR_WAIT + 2));
                acks++;
                wdata = db + 4'(acks);
            end
            if (!sram_notWE) nwe++;
            if (!sram_notOE) noe++;
            if (rdata_valid) nrv++;
            if (done) begin
                got = 1'b1;
                chk("done_cycle", cyc, exp_done);
                chk("idle_strobes", {sram_notCS, sram_notOE, sram_notWE}, 3'b111);
                chk("busy_fall", busy, 1'b0);
            end
            req = (cyc == glitch);
            if (cyc == glitch) we = ~w;
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
        chk("ack_count", acks, w ? n : 0);
        chk("we_low_cycles", nwe, w ? n * WR_WAIT : 0);
        chk("oe_low_cycles", noe, w ? 0 : n * RD_WAIT);
        chk("rvalid_count", nrv, w ? 0 : n);
        if (!chain) begin
            @(negedge clock);
            chk("single_done", done, 1'b0);
            chk("stay_idle", busy, 1'b0);
        end
    endtask

    typedef struct {
        bit         w;
        logic [3:0] a;
        logic [3:0] bl;
        logic [3:0] db;
        int         glitch;
        int         exp_done;
    } vec_t;

    vec_t vecs [8];
    int   k;

    initial begin
        vecs[0] = '{1'b1, 4'h0, 4'hF, 4'hE, 0, 65};  // full-length burst
        vecs[1] = '{1'b0, 4'h0, 4'hF, 4'h0, 0, 33};
        vecs[2] = '{1'b1, 4'h3, 4'h7, 4'h3, 0, 33};  // data = beat address
        vecs[3] = '{1'b0, 4'h3, 4'h7, 4'h0, 0, 17};
        vecs[4] = '{1'b1, 4'hF, 4'h1, 4'h5, 0, 9};   // address wrap F -> 0
        vecs[5] = '{1'b0, 4'hF, 4'h1, 4'h0, 0, 5};
        vecs[6] = '{1'b0, 4'h3, 4'h3, 4'h0, 3, 9};   // req pulsed mid-burst
        vecs[7] = '{1'b1, 4'h1, 4'h2, 4'hA, 6, 13};

        for (int i = 0; i < 16; i++) ref_mem[i] = 4'(i) ^ 4'h9;
        reset = 1'b1; init_en = 1'b1; req = 1'b0; we = 1'b0;
        addr = 4'h0; burst_len = 4'h0; wdata = 4'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_strobes", {sram_notCS, sram_notOE, sram_notWE}, 3'b111);
        chk("rst_addr", sram_addr, 4'h0);
        chk("rst_rdata", rdata, 4'h0);
        chk("rst_flags", {rdata_valid, wdata_ack, busy, done}, 4'b0000);
        reset = 1'b0; init_en = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            drive_req(vecs[i].w, vecs[i].a, vecs[i].bl, vecs[i].db);
            wait_cmd(vecs[i].w, vecs[i].bl, vecs[i].db, vecs[i].glitch, vecs[i].exp_done, 1'b0);
        end

        // Reset while WE is low: strobes release next cycle and no done appears.
        @(negedge clock);
        req = 1'b1; we = 1'b1; addr = 4'h5; burst_len = 4'h3; wdata = 4'h7;
        k = 0;
        while (k < 20) begin
            @(negedge clock);
            req = 1'b0;
            k++;
            if (!sram_notWE) break;
        end
        chk("abort_reach_pulse", sram_notWE, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_strobes", {sram_notCS, sram_notOE, sram_notWE}, 3'b111);
        chk("abort_flags", {busy, done, wdata_ack, rdata_valid}, 4'b0000);
        chk("abort_rdata", rdata, 4'h0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("abort_no_done", {busy, done}, 2'b00);
        end
        @(negedge clock);
        drive_req(1'b0, 4'h6, 4'h0, 4'h0);
        wait_cmd(1'b0, 4'h0, 4'h0, 0, 3, 1'b0);

        // Single write, then a read requested in the done cycle.
        @(negedge clock);
        drive_req(1'b1, 4'h9, 4'h0, 4'hC);
        wait_cmd(1'b1, 4'h0, 4'hC, 0, 5, 1'b1);
        drive_req(1'b0, 4'h9, 4'h0, 4'h0);
        wait_cmd(1'b0, 4'h0, 4'h0, 0, 3, 1'b0);

        repeat (2) @(negedge clock);
        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
